// File: rtl/i2c_ctrl_pkg.sv
// Shared types and constants for the I2C transaction arbiter and its clients.
package i2c_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_BUSY = 2'd1,
    RD_BUSY = 2'd2,
    GAP     = 2'd3
  } state_t;

  localparam logic [7:0] DS3231_WR_ADDR = 8'hD0;
  localparam logic [7:0] DS3231_RD_ADDR = 8'hD1;

  localparam int unsigned TMO_W = 12;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: search upward from ptr+1 with wrap, return one-hot and index.
module rr_arbiter #(
  parameter int unsigned NREQ  = 3,
  parameter int unsigned IDX_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  winner_c,
  output logic [IDX_W-1:0] idx_c,
  output logic             found_c
);

  int unsigned cand;

  always_comb begin
    winner_c = '0;
    idx_c    = '0;
    found_c  = 1'b0;
    cand     = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = 32'(ptr) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!found_c && req[IDX_W'(cand)]) begin
        found_c                  = 1'b1;
        winner_c[IDX_W'(cand)]   = 1'b1;
        idx_c                    = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Shares one I2C byte-write and one byte-read engine between NREQ requesters,
// with round-robin grant, an inter-transaction gap and a per-transaction watchdog.
module i2c_txn_arbiter
  import i2c_ctrl_pkg::*;
#(
  parameter int unsigned NREQ        = 3,
  parameter int unsigned GAP_CYC     = 4,
  parameter int unsigned TIMEOUT_CYC = 4095
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_wr,
  input  logic [8*NREQ-1:0] req_addr,
  input  logic [8*NREQ-1:0] req_wdat,
  output logic [NREQ-1:0]   req_done,
  output logic              req_err,
  output logic [7:0]        rsp_dat,
  output logic [NREQ-1:0]   grant,
  output logic              write_start,
  input  logic              write_over,
  output logic [7:0]        write_add,
  output logic [7:0]        write_dat,
  output logic              read_start,
  input  logic              read_over,
  output logic [7:0]        read_add,
  input  logic [7:0]        read_dat
);

  localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t            state, state_d;
  logic [IDX_W-1:0]  ptr, ptr_d;
  logic [TMO_W-1:0]  timer, timer_d;

  logic [NREQ-1:0]   grant_d, req_done_d;
  logic              req_err_d, write_start_d, read_start_d;
  logic [7:0]        rsp_dat_d, write_add_d, write_dat_d, read_add_d;

  logic [NREQ-1:0]   win;
  logic [IDX_W-1:0]  win_idx;
  logic              win_any;
  logic [7:0]        sel_addr, sel_wdat;
  logic              sel_wr;
  logic              tmo_hit;

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req      (req_valid),
    .ptr      (ptr),
    .winner_c (win),
    .idx_c    (win_idx),
    .found_c  (win_any)
  );

  // Mux the winning requester's payload out of the packed request buses.
  always_comb begin
    sel_addr = '0;
    sel_wdat = '0;
    sel_wr   = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win[i]) begin
        sel_addr = req_addr[8*i +: 8];
        sel_wdat = req_wdat[8*i +: 8];
        sel_wr   = req_wr[i];
      end
    end
  end

  assign tmo_hit = (timer == TMO_W'(TIMEOUT_CYC - 1));

  always_comb begin
    state_d       = state;
    ptr_d         = ptr;
    timer_d       = timer;
    grant_d       = grant;
    write_start_d = write_start;
    read_start_d  = read_start;
    write_add_d   = write_add;
    write_dat_d   = write_dat;
    read_add_d    = read_add;
    rsp_dat_d     = rsp_dat;
    req_done_d    = '0;
    req_err_d     = 1'b0;

    case (state)
      IDLE: begin
        if (win_any) begin
          grant_d = win;
          ptr_d   = win_idx;
          timer_d = '0;
          if (sel_wr) begin
            write_start_d = 1'b1;
            write_add_d   = sel_addr;
            write_dat_d   = sel_wdat;
            state_d       = WR_BUSY;
          end else begin
            read_start_d = 1'b1;
            read_add_d   = sel_addr;
            state_d      = RD_BUSY;
          end
        end
      end

      WR_BUSY: begin
        timer_d = timer + 1'b1;
        // Completion wins over a coincident watchdog expiry.
        if (write_over || tmo_hit) begin
          write_start_d = 1'b0;
          req_done_d    = grant;
          req_err_d     = !write_over;
          grant_d       = '0;
          timer_d       = '0;
          state_d       = GAP;
        end
      end

      RD_BUSY: begin
        timer_d = timer + 1'b1;
        if (read_over || tmo_hit) begin
          read_start_d = 1'b0;
          req_done_d   = grant;
          req_err_d    = !read_over;
          grant_d      = '0;
          timer_d      = '0;
          state_d      = GAP;
          if (read_over) rsp_dat_d = read_dat;
        end
      end

      GAP: begin
        timer_d = timer + 1'b1;
        if (timer == TMO_W'(GAP_CYC - 1)) begin
          timer_d = '0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= IDX_W'(NREQ - 1);
      timer       <= '0;
      grant       <= '0;
      write_start <= 1'b0;
      read_start  <= 1'b0;
      write_add   <= '0;
      write_dat   <= '0;
      read_add    <= '0;
      rsp_dat     <= '0;
      req_done    <= '0;
      req_err     <= 1'b0;
    end else begin
      state       <= state_d;
      ptr         <= ptr_d;
      timer       <= timer_d;
      grant       <= grant_d;
      write_start <= write_start_d;
      read_start  <= read_start_d;
      write_add   <= write_add_d;
      write_dat   <= write_dat_d;
      read_add    <= read_add_d;
      rsp_dat     <= rsp_dat_d;
      req_done    <= req_done_d;
      req_err     <= req_err_d;
    end
  end

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Self-checking bench for i2c_txn_arbiter: directed scenarios followed by randomized traffic.
module tb_i2c_txn_arbiter;

  localparam int unsigned NREQ        = 3;
  localparam int unsigned GAP_CYC     = 4;
  localparam int unsigned TIMEOUT_CYC = 4095;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid, req_wr;
  logic [8*NREQ-1:0] req_addr, req_wdat;
  logic [NREQ-1:0]   req_done, grant;
  logic              req_err, write_start, write_over, read_start, read_over;
  logic [7:0]        rsp_dat, write_add, write_dat, read_add, read_dat;

  always #5 clk = ~clk;

  i2c_txn_arbiter #(
    .NREQ        (NREQ),
    .GAP_CYC     (GAP_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_wr      (req_wr),
    .req_addr    (req_addr),
    .req_wdat    (req_wdat),
    .req_done    (req_done),
    .req_err     (req_err),
    .rsp_dat     (rsp_dat),
    .grant       (grant),
    .write_start (write_start),
    .write_over  (write_over),
    .write_add   (write_add),
    .write_dat   (write_dat),
    .read_start  (read_start),
    .read_over   (read_over),
    .read_add    (read_add),
    .read_dat    (read_dat)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: pending requests, their payloads, last served, last read byte.
  logic [NREQ-1:0] pend, drop;
  logic            f_wr   [NREQ];
  logic [7:0]      f_addr [NREQ];
  logic [7:0]      f_wdat [NREQ];
  int              last;
  logic [7:0]      rsp_exp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive();
    req_valid = pend & ~drop;
    for (int i = 0; i < NREQ; i++) begin
      req_wr[i]            = f_wr[i];
      req_addr[8*i +: 8]   = f_addr[i];
      req_wdat[8*i +: 8]   = f_wdat[i];
    end
  endtask

  task automatic set_req(input int i, input logic wr, input logic [7:0] a, input logic [7:0] d);
    pend[i]   = 1'b1;
    f_wr[i]   = wr;
    f_addr[i] = a;
    f_wdat[i] = d;
  endtask

  task automatic rand_req(input int i);
    set_req(i, 1'($urandom), 8'($urandom), 8'($urandom));
  endtask

  task automatic model_reset();
    last    = NREQ - 1;
    rsp_exp = 8'h00;
    pend    = '0;
    drop    = '0;
  endtask

  // Next requester served: first pending one after the last served, wrapping around.
  function automatic int rr_pick();
    for (int k = 1; k <= NREQ; k++) begin
      if (pend[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_grant"}, 32'(grant), 32'(0));
    check({tag, "_wstart"}, 32'(write_start), 32'(0));
    check({tag, "_rstart"}, 32'(read_start), 32'(0));
    check({tag, "_done"}, 32'(req_done), 32'(0));
  endtask

  task automatic gap_check();
    repeat (GAP_CYC) begin
      tick();
      check_idle("gap");
    end
  endtask

  // One full transaction from grant edge to completion edge, checked cycle by cycle.
  task automatic do_txn(input int lat, input bit stray, input bit tmo, input bit drop_it,
                        input logic [7:0] rd);
    int         w;
    int         cyc;
    logic       wr;
    logic [7:0] a;
    w = rr_pick();
    if (w < 0) begin
      $display("FAIL txn_setup: no pending request in model");
      $fatal(1);
    end
    wr = f_wr[w];
    a  = f_addr[w];
    drive();
    tick();
    check("grant", 32'(grant), 32'(1) << w);
    check("write_start", 32'(write_start), 32'(wr));
    check("read_start", 32'(read_start), 32'(!wr));
    if (wr) begin
      check("write_add", 32'(write_add), 32'(f_addr[w]));
      check("write_dat", 32'(write_dat), 32'(f_wdat[w]));
    end else begin
      check("read_add", 32'(read_add), 32'(f_addr[w]));
    end
    // Payload changes after grant must not reach the engine.
    f_addr[w] = 8'($urandom);
    f_wdat[w] = 8'($urandom);
    if (drop_it) drop[w] = 1'b1;
    drive();
    cyc = tmo ? int'(TIMEOUT_CYC) : lat;
    for (int c = 1; c < cyc; c++) begin
      if (stray && c == 1) begin
        if (wr) begin
          read_over = 1'b1;
          read_dat  = 8'($urandom);
        end else begin
          write_over = 1'b1;
        end
      end
      tick();
      read_over  = 1'b0;
      write_over = 1'b0;
      check("busy_start", 32'(wr ? write_start : read_start), 32'(1));
      check("busy_other", 32'(wr ? read_start : write_start), 32'(0));
      check("busy_done", 32'(req_done), 32'(0));
      check("busy_add", 32'(wr ? write_add : read_add), 32'(a));
    end
    if (!tmo) begin
      if (wr) write_over = 1'b1;
      else begin
        read_over = 1'b1;
        read_dat  = rd;
      end
    end
    tick();
    write_over = 1'b0;
    read_over  = 1'b0;
    check("done", 32'(req_done), 32'(1) << w);
    check("err", 32'(req_err), 32'(tmo));
    check("end_wstart", 32'(write_start), 32'(0));
    check("end_rstart", 32'(read_start), 32'(0));
    check("end_grant", 32'(grant), 32'(0));
    if (!tmo && !wr) rsp_exp = rd;
    check("rsp_dat", 32'(rsp_dat), 32'(rsp_exp));
    pend[w] = 1'b0;
    drop[w] = 1'b0;
    last    = w;
    drive();
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      check("start_exclusive", 32'(write_start & read_start), 32'(0));
      check("grant_onehot0", 32'($onehot0(grant)), 32'(1));
      check("done_onehot0", 32'($onehot0(req_done)), 32'(1));
    end
  end

  initial begin
    rst        = 1'b1;
    write_over = 1'b0;
    read_over  = 1'b0;
    read_dat   = 8'h00;
    req_valid  = '0;
    req_wr     = '0;
    req_addr   = '0;
    req_wdat   = '0;
    for (int i = 0; i < NREQ; i++) begin
      f_wr[i]   = 1'b0;
      f_addr[i] = 8'h00;
      f_wdat[i] = 8'h00;
    end
    model_reset();
    drive();
    repeat (3) tick();
    check_idle("reset");
    check("reset_err", 32'(req_err), 32'(0));
    check("reset_rsp", 32'(rsp_dat), 32'(0));
    check("reset_wadd", 32'(write_add), 32'(0));
    check("reset_wdat", 32'(write_dat), 32'(0));
    check("reset_radd", 32'(read_add), 32'(0));

    // Single write, engine finishes after 40 cycles.
    rst = 1'b0;
    set_req(0, 1'b1, 8'h0E, 8'h1C);
    do_txn(40, 1'b0, 1'b0, 1'b0, 8'h00);
    gap_check();

    // Single read from requester 2.
    set_req(2, 1'b0, 8'h00, 8'h00);
    do_txn(12, 1'b0, 1'b0, 1'b0, 8'h59);
    check("rsp_read_59", 32'(rsp_dat), 32'h59);
    gap_check();

    // Contention: all requesters held high from reset; expect 0,1,2,0.
    rst  = 1'b1;
    pend = '0;
    drive();
    tick();
    check_idle("rst2");
    model_reset();
    for (int i = 0; i < NREQ; i++) rand_req(i);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("order_pick", 32'(rr_pick()), 32'(k % NREQ));
      do_txn(5 + k, 1'b0, 1'b0, 1'b0, 8'($urandom));
      if (k < 3) rand_req(last);
      else pend = '0;
      drive();
      gap_check();
    end

    // Stray completion from the idle engine, then a requester dropping valid mid-flight.
    set_req(1, 1'b0, 8'h05, 8'h00);
    do_txn(8, 1'b1, 1'b0, 1'b0, 8'hA7);
    gap_check();
    set_req(0, 1'b1, 8'h0F, 8'h3C);
    do_txn(6, 1'b1, 1'b0, 1'b0, 8'h00);
    gap_check();
    set_req(2, 1'b1, 8'h07, 8'h11);
    do_txn(7, 1'b0, 1'b0, 1'b1, 8'h00);
    gap_check();

    // Watchdog: write engine never answers.
    set_req(1, 1'b1, 8'h0E, 8'h80);
    do_txn(0, 1'b0, 1'b1, 1'b0, 8'h00);
    gap_check();

    // Reset ten cycles into a read.
    set_req(1, 1'b0, 8'h33, 8'h00);
    drive();
    tick();
    check("rstmid_grant", 32'(grant), 32'b010);
    check("rstmid_rstart", 32'(read_start), 32'(1));
    repeat (10) tick();
    rst = 1'b1;
    tick();
    check_idle("rstmid");
    check("rstmid_err", 32'(req_err), 32'(0));
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < NREQ; i++) rand_req(i);
    check("rstmid_first", 32'(rr_pick()), 32'(0));
    do_txn(4, 1'b0, 1'b0, 1'b0, 8'($urandom));
    gap_check();

    // Randomized traffic against the model.
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) rand_req(i);
      end
      if (pend == '0) rand_req(int'($urandom_range(0, NREQ - 1)));
      do_txn(int'($urandom_range(1, 20)), ($urandom_range(0, 3) == 0), 1'b0,
             ($urandom_range(0, 3) == 0), 8'($urandom));
      gap_check();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
